// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - committed-store buffer draining in order over an AXI-Lite write master
module store_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] datafifo_addr_in,
    input  logic [31:0] datafifo_val_in,
    input  logic [1:0]  datafifo_size_in,
    input  logic        datafifo_valid_in,
    output logic        datafifo_full,
    output logic        datafifo_empty,
    output logic [31:0] axil_data_awaddr,
    output logic        axil_data_awvalid,
    input  logic        axil_data_awready,
    output logic [31:0] axil_data_wdata,
    output logic [3:0]  axil_data_wstrb,
    output logic        axil_data_wvalid,
    input  logic        axil_data_wready,
    input  logic [1:0]  axil_data_bresp,
    input  logic        axil_data_bvalid,
    output logic        axil_data_bready,
    output logic        store_fault_valid,
    output logic [31:0] store_fault_addr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    logic [31:0] addr_mem [DEPTH];
    logic [31:0] val_mem  [DEPTH];
    logic [1:0]  size_mem [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    state_t        state, state_nx;
    logic          aw_done, w_done, aw_done_nx, w_done_nx;
    logic          push, pop, bus_err;
    logic [31:0]   head_addr, head_val;
    logic [1:0]    head_size;

    assign datafifo_full  = (count == FULL_CNT);
    assign datafifo_empty = (count == '0) && (state == IDLE);
    assign push    = datafifo_valid_in && !datafifo_full;
    assign pop     = (state == RESP) && axil_data_bvalid;
    assign bus_err = pop && (axil_data_bresp != 2'b00);

    assign head_addr = addr_mem[rd_ptr];
    assign head_val  = val_mem[rd_ptr];
    assign head_size = size_mem[rd_ptr];

    // Entry storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= datafifo_addr_in;
            val_mem[wr_ptr]  <= datafifo_val_in;
            size_mem[wr_ptr] <= datafifo_size_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            state             <= IDLE;
            aw_done           <= 1'b0;
            w_done            <= 1'b0;
            store_fault_valid <= 1'b0;
            store_fault_addr  <= '0;
        end else begin
            state   <= state_nx;
            aw_done <= aw_done_nx;
            w_done  <= w_done_nx;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            store_fault_valid <= bus_err;
            if (bus_err) store_fault_addr <= head_addr;
        end
    end

    always_comb begin
        state_nx          = state;
        aw_done_nx        = aw_done;
        w_done_nx         = w_done;
        axil_data_awvalid = 1'b0;
        axil_data_wvalid  = 1'b0;
        axil_data_bready  = 1'b0;
        case (state)
            IDLE: if (count != '0) state_nx = REQ;
            REQ: begin
                axil_data_awvalid = !aw_done;
                axil_data_wvalid  = !w_done;
                // Handshakes landing this cycle count toward completion.
                if ((aw_done || axil_data_awready) && (w_done || axil_data_wready)) begin
                    state_nx   = RESP;
                    aw_done_nx = 1'b0;
                    w_done_nx  = 1'b0;
                end else begin
                    aw_done_nx = aw_done || axil_data_awready;
                    w_done_nx  = w_done || axil_data_wready;
                end
            end
            RESP: begin
                axil_data_bready = 1'b1;
                if (axil_data_bvalid) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign axil_data_awaddr = {head_addr[31:2], 2'b00};

    always_comb begin
        axil_data_wdata = head_val;
        axil_data_wstrb = 4'b1111;
        case (head_size)
            2'd0: begin
                axil_data_wdata = {4{head_val[7:0]}};
                axil_data_wstrb = 4'b0001 << head_addr[1:0];
            end
            2'd1: begin
                axil_data_wdata = {2{head_val[15:0]}};
                axil_data_wstrb = 4'b0011 << {head_addr[1], 1'b0};
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_store_fifo.sv
// tb/tb_store_fifo.sv - random and directed check of store_fifo against a queue model
module tb_store_fifo;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_in, val_in;
    logic [1:0]  size_in;
    logic        valid_in;
    logic        full, empty;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  bresp;
    logic        fault_valid;
    logic [31:0] fault_addr;

    int n_vec = 0;
    int n_err = 0;
    int aw_hs_cnt = 0;
    int b_hs_cnt = 0;

    always #5 clk = ~clk;

    store_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .datafifo_addr_in(addr_in), .datafifo_val_in(val_in),
        .datafifo_size_in(size_in), .datafifo_valid_in(valid_in),
        .datafifo_full(full), .datafifo_empty(empty),
        .axil_data_awaddr(awaddr), .axil_data_awvalid(awvalid), .axil_data_awready(awready),
        .axil_data_wdata(wdata), .axil_data_wstrb(wstrb),
        .axil_data_wvalid(wvalid), .axil_data_wready(wready),
        .axil_data_bresp(bresp), .axil_data_bvalid(bvalid), .axil_data_bready(bready),
        .store_fault_valid(fault_valid), .store_fault_addr(fault_addr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of accepted stores plus progress of the head transaction.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] val;
        logic [1:0]  size;
    } ent_t;

    ent_t        q[$];
    bit          busy, aw_seen, w_seen, wait_b, m_fault;
    logic [31:0] m_fault_addr;

    function automatic logic [31:0] exp_data(ent_t e);
        if (e.size == 2'd0) return 32'(e.val[7:0]) * 32'h0101_0101;
        if (e.size == 2'd1) return 32'(e.val[15:0]) * 32'h0001_0001;
        return e.val;
    endfunction

    function automatic logic [3:0] exp_strb(ent_t e);
        int a = int'(e.addr[1:0]);
        if (e.size == 2'd0) return 4'(1 << a);
        if (e.size == 2'd1) return 4'(3 << (a & 2));
        return 4'hF;
    endfunction

    always @(negedge clk) begin
        bit e_full, e_awv, e_wv, e_br, aw_hs, w_hs, b_hs;
        if (awvalid && awready) aw_hs_cnt++;
        if (bready && bvalid) b_hs_cnt++;
        if (!reset) begin
            q.delete();
            busy = 0; aw_seen = 0; w_seen = 0; wait_b = 0; m_fault = 0; m_fault_addr = '0;
        end
        e_full = (q.size() == DEPTH);
        e_awv  = busy && !wait_b && !aw_seen;
        e_wv   = busy && !wait_b && !w_seen;
        e_br   = busy && wait_b;
        check("full", 32'(full), 32'(e_full));
        check("empty", 32'(empty), 32'(q.size() == 0 && !busy));
        check("awvalid", 32'(awvalid), 32'(e_awv));
        check("wvalid", 32'(wvalid), 32'(e_wv));
        check("bready", 32'(bready), 32'(e_br));
        check("fault_valid", 32'(fault_valid), 32'(m_fault));
        check("fault_addr", fault_addr, m_fault_addr);
        if (e_awv) check("awaddr", awaddr, q[0].addr & 32'hFFFF_FFFC);
        if (e_wv) begin
            check("wdata", wdata, exp_data(q[0]));
            check("wstrb", 32'(wstrb), 32'(exp_strb(q[0])));
        end
        if (reset) begin
            aw_hs = e_awv && awready;
            w_hs  = e_wv && wready;
            b_hs  = e_br && bvalid;
            m_fault = b_hs && (bresp != 2'b00);
            if (m_fault) m_fault_addr = q[0].addr;
            if (!busy) begin
                if (q.size() != 0) busy = 1;
            end else if (!wait_b) begin
                aw_seen = aw_seen || aw_hs;
                w_seen  = w_seen || w_hs;
                if (aw_seen && w_seen) begin
                    wait_b = 1; aw_seen = 0; w_seen = 0;
                end
            end else if (b_hs) begin
                busy = 0; wait_b = 0;
                void'(q.pop_front());
            end
            if (valid_in && !e_full) q.push_back('{addr_in, val_in, size_in});
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
        addr_in = a; val_in = v; size_in = s; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    // which: 0 awvalid, 1 empty, 2 fault_valid, 3 bready; returns at the negedge it is seen.
    task automatic wait_for(input int which, input int limit, input string name);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((which == 0 && awvalid) || (which == 1 && empty) ||
                (which == 2 && fault_valid) || (which == 3 && bready)) return;
        end
        check({"timeout ", name}, 32'd0, 32'd1);
    endtask

    task automatic realign();
        @(posedge clk); #1;
    endtask

    initial begin
        int c0;
        reset = 1'b0; valid_in = 1'b0; addr_in = '0; val_in = '0; size_in = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        #2;
        check("reset empty", 32'(empty), 32'd1);
        check("reset full", 32'(full), 32'd0);
        check("reset fault_addr", fault_addr, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // single word store
        awready = 1; wready = 1; bvalid = 1; bresp = 0;
        push(32'h1000, 32'hDEAD_BEEF, 2'd2);
        wait_for(0, 10, "t1 aw");
        check("t1 awaddr", awaddr, 32'h1000);
        check("t1 wdata", wdata, 32'hDEAD_BEEF);
        check("t1 wstrb", 32'(wstrb), 32'hF);
        realign();
        wait_for(1, 10, "t1 empty");
        check("t1 empty", 32'(empty), 32'd1);
        realign();

        // byte then half lane replication
        push(32'h2003, 32'h0000_00AB, 2'd0);
        push(32'h2002, 32'h0000_1234, 2'd1);
        wait_for(0, 10, "t2 aw0");
        check("t2 wdata0", wdata, 32'hABAB_ABAB);
        check("t2 wstrb0", 32'(wstrb), 32'h8);
        realign();
        wait_for(0, 10, "t2 aw1");
        check("t2 wdata1", wdata, 32'h1234_1234);
        check("t2 wstrb1", 32'(wstrb), 32'hC);
        realign();
        wait_for(1, 10, "t2 empty");
        realign();

        // overflow while stalled
        awready = 0; wready = 0;
        for (int i = 0; i < 5; i++) push(32'h4000 + 32'(4 * i), 32'(i), 2'd2);
        check("t3 full", 32'(full), 32'd1);
        c0 = aw_hs_cnt;
        awready = 1; wready = 1;
        wait_for(1, 60, "t3 empty");
        check("t3 aw count", 32'(aw_hs_cnt - c0), 32'd4);
        realign();

        // W accepted before AW
        awready = 0; wready = 1;
        c0 = b_hs_cnt;
        push(32'h4100, 32'h5555_AAAA, 2'd2);
        repeat (5) @(posedge clk);
        #1 awready = 1;
        wait_for(1, 20, "t4 empty");
        check("t4 b count", 32'(b_hs_cnt - c0), 32'd1);
        realign();

        // error response
        bresp = 2'b10;
        push(32'h3004, 32'h1111_1111, 2'd2);
        push(32'h3008, 32'h2222_2222, 2'd2);
        wait_for(2, 20, "t5 fault");
        check("t5 fault_addr", fault_addr, 32'h3004);
        #1 bresp = 2'b00;
        wait_for(0, 10, "t5 aw next");
        check("t5 next awaddr", awaddr, 32'h3008);
        check("t5 pulse width", 32'(fault_valid), 32'd0);
        realign();
        wait_for(1, 20, "t5 empty");
        realign();

        // reset while awaiting B with entries queued
        bvalid = 0;
        push(32'h5000, 32'h1, 2'd2);
        push(32'h5004, 32'h2, 2'd2);
        push(32'h5008, 32'h3, 2'd2);
        wait_for(3, 20, "t6 resp");
        realign();
        reset = 1'b0;
        #1;
        check("t6 awvalid", 32'(awvalid), 32'd0);
        check("t6 bready", 32'(bready), 32'd0);
        check("t6 empty", 32'(empty), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        c0 = aw_hs_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("t6 no aw", 32'(aw_hs_cnt - c0), 32'd0);
        check("t6 empty after", 32'(empty), 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            valid_in = ($urandom_range(0, 1) == 1);
            addr_in  = $urandom;
            val_in   = $urandom;
            size_in  = 2'($urandom_range(0, 3));
            awready  = ($urandom_range(0, 9) < 6);
            wready   = ($urandom_range(0, 9) < 6);
            bvalid   = ($urandom_range(0, 1) == 1);
            bresp    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            @(posedge clk); #1;
        end
        valid_in = 0; awready = 1; wready = 1; bvalid = 1; bresp = 0;
        wait_for(1, 200, "drain empty");
        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
